piso_serializer: RTL and testbench
==================================

PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 The module SHALL expose these parameters:
- WIDTH, default 4: bits per word; legal values are 2 or more.
- MSB_FIRST, default 1: 1 shifts din[WIDTH-1] out first; 0 shifts din[0] out first.
- GAP, default 0: number of idle cycles inserted between frames; legal values are 0 to 15.

REQ-002 The module SHALL expose these ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- din  in  WIDTH  parallel word to serialize.
- din_valid  in  1  din is valid.
- din_ready  out  1  block accepts din this cycle.
- sout  out  1  serial data bit; feeds the downstream shift register's serial input.
- sout_valid  out  1  sout carries a frame bit.
- frame_start  out  1  high with the first bit of each frame.
- frame_end  out  1  high with the last bit of each frame.
- busy  out  1  a frame or gap is in progress.

Function
REQ-003 The block SHALL implement three states: IDLE, SHIFT and GAP.
REQ-004 A transfer SHALL occur on a rising edge where din_valid and din_ready are both 1.
- din is captured into an internal WIDTH-bit shift register.
- The bit counter is cleared to 0.
- The state moves to SHIFT.
REQ-005 din_valid and din SHALL be ignored while din_ready is 0; no word is dropped or duplicated.
REQ-006 din_ready SHALL be 1 in two cases only:
- in IDLE;
- in the last SHIFT cycle (counter = WIDTH-1) when GAP = 0.
REQ-007 Latency: the first frame bit SHALL appear on sout in the cycle immediately after the accepting edge.
REQ-008 In SHIFT, each cycle SHALL present exactly one bit on sout with sout_valid = 1.
- Bit order follows MSB_FIRST.
- The counter increments by 1 per cycle.
REQ-009 frame_start SHALL be 1 only when counter = 0 in SHIFT; frame_end SHALL be 1 only when counter = WIDTH-1 in SHIFT.
REQ-010 At the end of the last bit (counter = WIDTH-1):
- A transfer on that edge SHALL start the next frame with zero dead cycles (legal only when GAP = 0).
- Otherwise, with GAP = 0, the state SHALL go to IDLE.
- Otherwise, with GAP > 0, the state SHALL go to GAP.
REQ-011 GAP state SHALL last exactly GAP cycles, using the same counter, then return to IDLE.
REQ-012 Outside SHIFT, sout, sout_valid, frame_start and frame_end SHALL be 0.
REQ-013 busy SHALL be 1 in SHIFT and GAP, and 0 in IDLE.
REQ-014 The counter SHALL be $clog2(WIDTH) bits wide, or 4 bits if that is larger, and SHALL never wrap inside a frame.
REQ-015 All outputs SHALL be registered or decoded from registered state only; there is no combinational path from din or din_valid to any output except din_ready, which depends on state only.

Reset
REQ-016 While rst = 1 the block SHALL be forced to IDLE:
- counter = 0 and shift register = 0;
- sout, sout_valid, frame_start, frame_end and busy all 0;
- din_ready = 0.
REQ-017 The first cycle after rst deasserts SHALL present din_ready = 1.
REQ-018 Reset asserted mid-frame or mid-gap SHALL abort the frame immediately.
- The partial word is discarded.
- No further bits of that frame are emitted after reset releases.

Verification
REQ-019 WIDTH=4, MSB_FIRST=1, GAP=0; din=4'b1011 with a single-cycle valid:
- sout = 1,0,1,1 on four consecutive cycles with sout_valid = 1;
- frame_start is high on cycle 1 and frame_end on cycle 4;
- a downstream 4-bit shift register shows 4'b1011 after the 4th bit.
REQ-020 Back-to-back words 4'hA then 4'h5, with din_valid held high:
- 8 contiguous valid cycles carrying 1,0,1,0,0,1,0,1;
- din_ready pulses high in cycle 4;
- there is no idle cycle between the frames.
REQ-021 GAP=2, two words queued:
- exactly 2 cycles with sout_valid = 0 and busy = 1 between the frames;
- din_ready stays 0 during those 2 cycles.
REQ-022 MSB_FIRST=0, din=4'b0001 -> sout = 1,0,0,0.
REQ-023 Reset asserted after 2 bits of 4'b1111:
- all outputs go to 0 immediately;
- after release, sout_valid stays 0 until a new transfer occurs, and the next frame is emitted complete.
REQ-024 din_valid held high with a changing din while busy:
- only the value present on the accepting edge is serialized;
- intermediate values never appear on sout.

Source files
------------

// File: rtl/piso_serializer_if.sv
// Parallel-in / serial-out handshake bundle: a word goes in on the valid/ready pair,
// and the serial bit stream comes out with its framing and status flags.
interface piso_serializer_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             sout;
  logic             sout_valid;
  logic             frame_start;
  logic             frame_end;
  logic             busy;

  // master drives words in and watches the serial side; slave is the serializer
  modport master (
    output din, din_valid,
    input  din_ready, sout, sout_valid, frame_start, frame_end, busy
  );

  modport slave (
    input  din, din_valid,
    output din_ready, sout, sout_valid, frame_start, frame_end, busy
  );
endinterface

// File: rtl/piso_serializer.sv
// Serializes one WIDTH-bit word per frame onto sout, with optional idle GAP cycles
// between frames. A word transfers on a clock edge where din_valid and din_ready are both 1.
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1,
  parameter int GAP       = 0
) (
  input  logic                clk,
  input  logic                rst,
  piso_serializer_if.slave    bus,
  output logic [1:0]          state_dbg
);

  localparam int CW = ($clog2(WIDTH) > 4) ? $clog2(WIDTH) : 4;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'((GAP > 0) ? (GAP - 1) : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_next;
  logic             last_bit;
  logic             accept;

  assign last_bit = (state == S_SHIFT) && (cnt == CNT_LAST);
  assign sr_next  = MSB_FIRST ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};
  assign accept   = bus.din_valid && bus.din_ready;

  // Ready is decoded from state alone (gated by reset) so din_valid never loops back into it.
  assign bus.din_ready = !rst && ((state == S_IDLE) || ((GAP == 0) && last_bit));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      sr    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            sr    <= bus.din;
            cnt   <= '0;
            state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (accept) begin
              // zero-dead-cycle chaining into the next frame
              sr <= bus.din;
            end else begin
              sr    <= sr_next;
              state <= (GAP == 0) ? S_IDLE : S_GAP;
            end
          end else begin
            sr  <= sr_next;
            cnt <= cnt + CW'(1);
          end
        end
        S_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.sout        = (state == S_SHIFT) && (MSB_FIRST ? sr[WIDTH-1] : sr[0]);
  assign bus.sout_valid  = (state == S_SHIFT);
  assign bus.frame_start = (state == S_SHIFT) && (cnt == '0);
  assign bus.frame_end   = last_bit;
  assign bus.busy        = (state != S_IDLE);
  assign state_dbg       = state;

endmodule

// File: tb/tb_piso_serializer.sv
// Drives two serializers (MSB-first/no gap and LSB-first/gap of 2) with the same word
// stream and checks every cycle against a per-cycle expected-output timeline.
module tb_piso_serializer;

  localparam int WIDTH = 4;
  localparam int GAP_B = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic [1:0]       state_a;
  logic [1:0]       state_b;
  logic [WIDTH-1:0] ds_reg;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // entry layout: {busy, sout_valid, sout, frame_start, frame_end}
  logic [4:0] exp_q_a[$];
  logic [4:0] exp_q_b[$];

  piso_serializer_if #(.WIDTH(WIDTH)) bus_a ();
  piso_serializer_if #(.WIDTH(WIDTH)) bus_b ();

  assign bus_a.din       = din;
  assign bus_a.din_valid = din_valid;
  assign bus_b.din       = din;
  assign bus_b.din_valid = din_valid;

  piso_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1), .GAP(0)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a.slave), .state_dbg(state_a)
  );

  piso_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0), .GAP(GAP_B)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b.slave), .state_dbg(state_b)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // downstream shift register fed by serializer A
  always @(posedge clk) begin
    if (rst) ds_reg <= '0;
    else if (bus_a.sout_valid) ds_reg <= {ds_reg[WIDTH-2:0], bus_a.sout};
  end

  task automatic compare(input string name, input logic [4:0] got, input logic [4:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, got, exp);
    end
  endtask

  // One cycle of the reference model: pop this cycle's expected outputs, derive
  // the expected ready, and on a modelled transfer append the new frame and gap.
  task automatic step(input int id, input logic [4:0] got, input logic rdy);
    logic [4:0] cur;
    logic       empty_after;
    logic       exp_rdy;
    logic       msb;
    int         gap;
    msb = (id == 0);
    gap = (id == 0) ? 0 : GAP_B;
    cur = '0;
    exp_rdy = 1'b0;
    if (rst) begin
      if (id == 0) exp_q_a.delete(); else exp_q_b.delete();
    end else begin
      if (id == 0) begin
        if (exp_q_a.size() > 0) cur = exp_q_a.pop_front();
        empty_after = (exp_q_a.size() == 0);
      end else begin
        if (exp_q_b.size() > 0) cur = exp_q_b.pop_front();
        empty_after = (exp_q_b.size() == 0);
      end
      exp_rdy = empty_after && ((cur == 5'b0) || (cur[0] && gap == 0));
    end
    compare((id == 0) ? "a_outputs" : "b_outputs", got, cur);
    compare((id == 0) ? "a_din_ready" : "b_din_ready", {4'b0, rdy}, {4'b0, exp_rdy});
    if (!rst && exp_rdy && din_valid) begin
      for (int i = 0; i < WIDTH; i++) begin
        logic b;
        b = msb ? din[WIDTH-1-i] : din[i];
        if (id == 0) exp_q_a.push_back({1'b1, 1'b1, b, i == 0, i == WIDTH - 1});
        else         exp_q_b.push_back({1'b1, 1'b1, b, i == 0, i == WIDTH - 1});
      end
      for (int g = 0; g < gap; g++) begin
        if (id == 0) exp_q_a.push_back(5'b10000);
        else         exp_q_b.push_back(5'b10000);
      end
    end
  endtask

  // monitor: sampled mid-cycle, away from the active edge
  always @(negedge clk) begin
    step(0, {bus_a.busy, bus_a.sout_valid, bus_a.sout, bus_a.frame_start, bus_a.frame_end},
         bus_a.din_ready);
    step(1, {bus_b.busy, bus_b.sout_valid, bus_b.sout, bus_b.frame_start, bus_b.frame_end},
         bus_b.din_ready);
  end

  // driver tasks
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [WIDTH-1:0] w);
    logic done;
    done = 1'b0;
    din = w;
    din_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (bus_a.din_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL a_accept_timeout at cycle %0d: got no transfer expected one within 50 cycles", cyc);
    end
  endtask

  initial begin
    rst = 1'b1;
    din = '0;
    din_valid = 1'b0;
    repeat (3) cycle();
    rst = 1'b0;
    cycle();

    // single word, single-cycle valid
    send_a(4'b1011);
    din_valid = 1'b0;
    repeat (8) cycle();
    compare("a_downstream_word", {1'b0, ds_reg}, {1'b0, 4'b1011});

    // back-to-back with valid held high
    send_a(4'hA);
    send_a(4'h5);
    din_valid = 1'b0;
    repeat (10) cycle();

    send_a(4'b0001);
    din_valid = 1'b0;
    repeat (10) cycle();

    // reset two bits into a frame
    send_a(4'b1111);
    din_valid = 1'b0;
    cycle();
    rst = 1'b1;
    #1;
    compare("a_reset_immediate",
            {bus_a.busy, bus_a.sout_valid, bus_a.sout, bus_a.frame_start, bus_a.din_ready},
            5'b0);
    repeat (2) cycle();
    rst = 1'b0;
    repeat (4) cycle();
    send_a(4'b0110);
    din_valid = 1'b0;
    repeat (10) cycle();

    // randomized traffic with changing din and occasional reset
    for (int i = 0; i < 400; i++) begin
      din = WIDTH'($urandom_range(0, 15));
      din_valid = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 99) == 0);
      cycle();
    end
    rst = 1'b0;
    din_valid = 1'b0;
    repeat (12) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
